// File: rtl/qcl_pkg.sv
// Shared types and helpers for the time-slice arbiter.
// Holds the FSM state encoding and the per-requester limit extraction.
package qcl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } qcl_tsa_state_e;

    localparam int QCL_FLAT_W  = 1024;
    localparam int QCL_SLICE_W = 32;

    typedef logic [QCL_FLAT_W-1:0] qcl_flat_t;

    // Extracts entry idx of width w from a flat packed vector of entries.
    function automatic logic [QCL_SLICE_W-1:0] qcl_limit_at(
        input qcl_flat_t flat,
        input int        idx,
        input int        w
    );
        qcl_flat_t               shifted;
        logic [QCL_SLICE_W-1:0]  mask;
        shifted = flat >> (idx * w);
        mask    = (w >= QCL_SLICE_W) ? '1 : ((32'd1 << w) - 32'd1);
        return shifted[QCL_SLICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/qcl_rr_pick.sv
// Rotate-priority picker: first eligible requester at or after ptr, wrapping.
// Purely combinational; one-hot pick, its index and a found flag.
module qcl_rr_pick #(
    parameter int els_p = 4
) (
    input  logic [els_p-1:0]         eligible,
    input  logic [$clog2(els_p)-1:0] ptr,
    output logic [els_p-1:0]         pick,
    output logic [$clog2(els_p)-1:0] pick_id,
    output logic                     found
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int pos_w_lp  = lg_els_lp + 1;

    logic [pos_w_lp-1:0] pos;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < els_p; i++) begin
            pos = {1'b0, ptr} + pos_w_lp'(i);
            if (pos >= pos_w_lp'(els_p)) begin
                pos = pos - pos_w_lp'(els_p);
            end
            if (!found && eligible[pos[lg_els_lp-1:0]]) begin
                found                      = 1'b1;
                pick_id                    = pos[lg_els_lp-1:0];
                pick[pos[lg_els_lp-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qcl_timeslice_arbiter.sv
// Round-robin time-slice arbiter: each holder keeps the grant for its latched
// slice length (in en_i ticks) or until it drops its request, then a 1-cycle gap.
module qcl_timeslice_arbiter
    import qcl_pkg::*;
#(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic [els_p-1:0]           req_i,
    input  logic [els_p*width_p-1:0]   limit_i,
    output logic [els_p-1:0]           grant_o,
    output logic                       grant_v_o,
    output logic [$clog2(els_p)-1:0]   grant_id_o,
    output logic [width_p-1:0]         slice_cnt_o,
    output logic                       slice_done_o
);

    localparam int lg_els_lp = $clog2(els_p);

    qcl_tsa_state_e         state_r, state_n;
    logic [lg_els_lp-1:0]   ptr_r, ptr_n;
    logic [lg_els_lp-1:0]   id_r, id_n;
    logic [els_p-1:0]       grant_r, grant_n;
    logic                   v_r, v_n;
    logic [width_p-1:0]     cnt_r, cnt_n;
    logic [width_p-1:0]     lim_r, lim_n;

    logic [els_p-1:0]       eligible;
    logic [els_p-1:0]       pick;
    logic [lg_els_lp-1:0]   pick_id;
    logic                   found;
    logic [width_p-1:0]     pick_lim;
    logic [width_p-1:0]     cnt_inc;
    logic                   slice_end;
    qcl_flat_t              limit_flat;

    assign limit_flat = qcl_flat_t'(limit_i);

    always_comb begin
        for (int k = 0; k < els_p; k++) begin
            eligible[k] = req_i[k] & (qcl_limit_at(limit_flat, k, width_p) != '0);
        end
    end

    qcl_rr_pick #(.els_p(els_p)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_r),
        .pick     (pick),
        .pick_id  (pick_id),
        .found    (found)
    );

    assign pick_lim = width_p'(qcl_limit_at(limit_flat, int'(pick_id), width_p));
    assign cnt_inc  = cnt_r + width_p'(1);

    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        id_n      = id_r;
        grant_n   = grant_r;
        v_n       = v_r;
        cnt_n     = cnt_r;
        lim_n     = lim_r;
        slice_end = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                cnt_n = '0;
                if (found) begin
                    state_n = GRANT;
                    grant_n = pick;
                    id_n    = pick_id;
                    v_n     = 1'b1;
                    lim_n   = pick_lim;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    id_n    = '0;
                    v_n     = 1'b0;
                end
            end
            GRANT: begin
                // A dropped request ends the slice even without a tick.
                slice_end = !req_i[id_r] || (en_i && (cnt_inc == lim_r));
                if (slice_end) begin
                    state_n = GAP;
                    ptr_n   = (id_r == lg_els_lp'(els_p - 1)) ? '0 : id_r + lg_els_lp'(1);
                    cnt_n   = '0;
                    grant_n = '0;
                    id_n    = '0;
                    v_n     = 1'b0;
                end else if (en_i) begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            id_r    <= '0;
            grant_r <= '0;
            v_r     <= 1'b0;
            cnt_r   <= '0;
            lim_r   <= '0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            id_r    <= id_n;
            grant_r <= grant_n;
            v_r     <= v_n;
            cnt_r   <= cnt_n;
            lim_r   <= lim_n;
        end
    end

    assign grant_o      = grant_r;
    assign grant_v_o    = v_r;
    assign grant_id_o   = id_r;
    assign slice_cnt_o  = cnt_r;
    assign slice_done_o = slice_end;

endmodule

// File: tb/tb_qcl_timeslice_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a holder/ticks-used reference model.
module tb_qcl_timeslice_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               en;
    logic [N-1:0]       req;
    logic [N*W-1:0]     limit;
    logic [N-1:0]       grant;
    logic               grant_v;
    logic [1:0]         grant_id;
    logic [W-1:0]       slice_cnt;
    logic               slice_done;

    always #5 clk = ~clk;

    qcl_timeslice_arbiter #(.els_p(N), .width_p(W)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .en_i         (en),
        .req_i        (req),
        .limit_i      (limit),
        .grant_o      (grant),
        .grant_v_o    (grant_v),
        .grant_id_o   (grant_id),
        .slice_cnt_o  (slice_cnt),
        .slice_done_o (slice_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the grant, ticks used, latched length, pointer.
    int m_holder = -1;
    int m_used   = 0;
    int m_len    = 0;
    int m_ptr    = 0;

    logic [N-1:0] obs_grant;
    logic         obs_v;
    int           obs_id;
    int           obs_cnt;
    logic         obs_done;
    int           done_cnt;
    int           cur_len;
    logic         prev_v;
    int           starts[$];
    int           lens[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit req_of(int k);
        return 1'(req >> k);
    endfunction

    function automatic int lim_of(int k);
        return int'(W'(limit >> (k * W)));
    endfunction

    function automatic logic [N*W-1:0] lims(int a0, int a1, int a2, int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic clear_stats();
        done_cnt = 0;
        cur_len  = 0;
        prev_v   = 1'b0;
        starts.delete();
        lens.delete();
    endtask

    // Entered at posedge+1; drives inputs, checks at negedge, advances model.
    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic e);
        logic         exp_v;
        logic [N-1:0] exp_grant;
        int           exp_id;
        int           exp_cnt;
        logic         exp_done;
        req   = r;
        limit = l;
        en    = e;
        @(negedge clk);
        exp_v     = (m_holder >= 0);
        exp_grant = exp_v ? N'(1 << m_holder) : '0;
        exp_id    = exp_v ? m_holder : 0;
        exp_cnt   = exp_v ? m_used : 0;
        exp_done  = exp_v && (!req_of(m_holder) || (e && (m_used + 1 == m_len)));
        check("grant",      32'(grant),      32'(exp_grant));
        check("grant_v",    32'(grant_v),    32'(exp_v));
        check("grant_id",   32'(grant_id),   32'(exp_id));
        check("slice_cnt",  32'(slice_cnt),  32'(exp_cnt));
        check("slice_done", 32'(slice_done), 32'(exp_done));
        obs_grant = grant;
        obs_v     = grant_v;
        obs_id    = int'(grant_id);
        obs_cnt   = int'(slice_cnt);
        obs_done  = slice_done;
        if (grant_v && !prev_v) starts.push_back(int'(grant_id));
        if (grant_v) cur_len++;
        if (slice_done) begin
            done_cnt++;
            lens.push_back(cur_len);
            cur_len = 0;
        end
        prev_v = grant_v;
        if (exp_v) begin
            if (exp_done) begin
                m_ptr    = (m_holder + 1) % N;
                m_holder = -1;
            end else if (e) begin
                m_used++;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (req_of(k) && lim_of(k) != 0) begin
                    m_holder = k;
                    m_used   = 0;
                    m_len    = lim_of(k);
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_grant",   32'(grant),      32'd0);
        check("rst_grant_v", 32'(grant_v),    32'd0);
        check("rst_id",      32'(grant_id),   32'd0);
        check("rst_cnt",     32'(slice_cnt),  32'd0);
        check("rst_done",    32'(slice_done), 32'd0);
        req      = '0;
        m_holder = -1;
        m_used   = 0;
        m_ptr    = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
    endtask

    function automatic int q_at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int exp_order[5];
        int exp_lens[4];
        int la[N];
        bit seen2;
        reset_n = 1'b0;
        req     = '0;
        limit   = '0;
        en      = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant_v", 32'(grant_v), 32'd0);
        check("reset_grant",   32'(grant),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-grant, then first grant goes to id 0.
        repeat (2) cycle(4'b1111, lims(2, 2, 2, 2), 1'b1);
        check("t1_pre_v", 32'(obs_v), 32'd1);
        do_reset();
        cycle(4'b1111, lims(2, 2, 2, 2), 1'b1);
        cycle(4'b1111, lims(2, 2, 2, 2), 1'b1);
        check("t1_first_v",  32'(obs_v),  32'd1);
        check("t1_first_id", 32'(obs_id), 32'd0);

        // Round-robin with limits {3,2,1,4}.
        do_reset();
        repeat (16) cycle(4'b1111, lims(3, 2, 1, 4), 1'b1);
        exp_order = '{0, 1, 2, 3, 0};
        exp_lens  = '{3, 2, 1, 4};
        check("t2_nstarts", 32'(starts.size()), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 32'(q_at(starts, i)), 32'(exp_order[i]));
        for (int i = 0; i < 4; i++) check($sformatf("t2_len%0d", i), 32'(q_at(lens, i)), 32'(exp_lens[i]));
        check("t2_done_cnt", 32'(done_cnt), 32'd4);

        // Early release of holder 1 at cnt=3.
        do_reset();
        repeat (4) cycle(4'b0110, lims(10, 10, 10, 10), 1'b1);
        check("t3_holder", 32'(obs_id), 32'd1);
        cycle(4'b0100, lims(10, 10, 10, 10), 1'b1);
        check("t3_cnt",  32'(obs_cnt),  32'd3);
        check("t3_done", 32'(obs_done), 32'd1);
        cycle(4'b0100, lims(10, 10, 10, 10), 1'b1);
        check("t3_gap_v", 32'(obs_v), 32'd0);
        cycle(4'b0100, lims(10, 10, 10, 10), 1'b1);
        check("t3_next_v",  32'(obs_v),  32'd1);
        check("t3_next_id", 32'(obs_id), 32'd2);

        // Tick gating: en pattern 1,0,0,1 with limit 2.
        do_reset();
        cycle(4'b0001, lims(2, 0, 0, 0), 1'b1);
        cycle(4'b0001, lims(2, 0, 0, 0), 1'b1);
        check("t4_c0", 32'(obs_cnt), 32'd0);
        check("t4_d0", 32'(obs_done), 32'd0);
        cycle(4'b0001, lims(2, 0, 0, 0), 1'b0);
        check("t4_c1", 32'(obs_cnt), 32'd1);
        cycle(4'b0001, lims(2, 0, 0, 0), 1'b0);
        check("t4_c2", 32'(obs_cnt), 32'd1);
        check("t4_d2", 32'(obs_done), 32'd0);
        cycle(4'b0001, lims(2, 0, 0, 0), 1'b1);
        check("t4_c3", 32'(obs_cnt), 32'd1);
        check("t4_d3", 32'(obs_done), 32'd1);

        // Zero limit masks requester 2.
        do_reset();
        seen2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(4'b1111, lims(3, 2, 0, 1), 1'($urandom_range(3, 0) != 0));
            if (obs_v && obs_id == 2) seen2 = 1'b1;
        end
        check("t5_masked", 32'(seen2), 32'd0);

        // Limit change mid-slice only affects the next slice.
        do_reset();
        repeat (3) cycle(4'b0001, lims(5, 0, 0, 0), 1'b1);
        repeat (7) cycle(4'b0001, lims(2, 0, 0, 0), 1'b1);
        check("t5_len0", 32'(q_at(lens, 0)), 32'd5);
        check("t5_len1", 32'(q_at(lens, 1)), 32'd2);

        // Single requester with limit 1 alternates grant and gap.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(4'b1000, lims(0, 0, 0, 1), 1'b1);
            check($sformatf("t6_grant%0d", i), 32'(obs_grant), (i % 2 == 1) ? 32'd8 : 32'd0);
        end

        // Largest slice length at width_p.
        do_reset();
        repeat (258) cycle(4'b0001, lims(255, 0, 0, 0), 1'b1);
        check("tmax_len", 32'(q_at(lens, 0)), 32'd255);

        // Random traffic.
        do_reset();
        for (int k = 0; k < N; k++) la[k] = $urandom_range(5, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(3, 0) != 0);
            if ($urandom_range(7, 0) == 0) la[$urandom_range(N - 1, 0)] = $urandom_range(6, 0);
            if ($urandom_range(299, 0) == 0) do_reset();
            cycle(r, lims(la[0], la[1], la[2], la[3]), 1'($urandom_range(9, 0) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
